// File: rtl/shift_ctrl_pkg.sv
// Shared state encodings and width helper for the serial shift sequencer.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so counters always have at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shift_reg.sv
// Downstream serial shift register: DEPTH stages, shifts every clock.
module shift_reg #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic s_data,
  output logic q
);

  logic [DEPTH-1:0] stage_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (clr) stage_reg[gi] <= 1'b0;
          else     stage_reg[gi] <= s_data;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (clr) stage_reg[gi] <= 1'b0;
          else     stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame serializer: takes a parallel word, shifts it out one bit per clock,
// flushes until the last bit reaches the shift register output, then pulses done.
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             s_data,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frame_cnt
);

  localparam int BIT_W = clog2(WIDTH);
  localparam int FL_W  = clog2(DEPTH + 1);

  state_t           state_reg, state_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [FL_W-1:0]  flush_cnt_reg, flush_cnt_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic             s_data_reg, s_data_next;
  logic             done_reg, done_next;
  logic [7:0]       frame_cnt_reg, frame_cnt_next;
  logic [BIT_W-1:0] sel_idx;

  // bit_cnt is the position in send order; map it to a word index.
  assign sel_idx = MSB_FIRST ? (BIT_W'(WIDTH - 1) - bit_cnt_reg) : bit_cnt_reg;

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    shadow_next    = shadow_reg;
    s_data_next    = 1'b0;
    done_next      = 1'b0;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          shadow_next  = in_data;
          s_data_next  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
          bit_cnt_next = BIT_W'(1);
          state_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        s_data_next  = shadow_reg[sel_idx];
        bit_cnt_next = bit_cnt_reg + 1'b1;
        if (bit_cnt_reg == BIT_W'(WIDTH - 1)) begin
          bit_cnt_next   = '0;
          flush_cnt_next = '0;
          state_next     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush_cnt_next = flush_cnt_reg + 1'b1;
        // Last flush edge: the final data bit lands on the shift register output.
        if (flush_cnt_reg == FL_W'(DEPTH - 1)) begin
          done_next      = 1'b1;
          frame_cnt_next = frame_cnt_reg + 8'd1;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
      shadow_reg    <= '0;
      s_data_reg    <= 1'b0;
      done_reg      <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      shadow_reg    <= shadow_next;
      s_data_reg    <= s_data_next;
      done_reg      <= done_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign s_data    = s_data_reg;
  assign done      = done_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule
